inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_fifo.sv | 78 +++++++
 rtl/inst_fetch.sv | 115 +++++++++++
 tb/tb_inst_fetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared instruction types and constants for the fetch stage and its consumers.
package inst_fetch_pkg;

    typedef logic [31:0] instr_t;

    // addi x0, x0, 0
    localparam instr_t NOP = 32'h0000_0013;

    // Wide enough to count up to the largest legal DEPTH (4).
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        instr_t      inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs; flush wins over push/pop.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: a pop frees the slot, so push is accepted when full if a pop coincides.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word requests, tracks in-flight responses, drops responses
// orphaned by a redirect and buffers the rest for the decoder.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output instr_t      out_inst,
    output logic [31:0] out_pc
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             grant;
    logic             rvalid_ok;
    logic             dropping;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;

    // Request/response bookkeeping; a redirect suppresses request, push and pop.
    always_comb begin
        in_flight  = outst_q + fifo_count;
        // Gating with rst_n keeps the request low while reset is held.
        imem_req   = rst_n && !redirect_en && (in_flight < DEPTH_C);
        grant      = imem_req && imem_gnt;
        // Responses with nothing outstanding are stray and ignored entirely.
        rvalid_ok  = imem_rvalid && (outst_q != '0);
        dropping   = rvalid_ok && (discard_q != '0);
        push       = rvalid_ok && !dropping && !redirect_en;
        pop        = out_valid && out_ready && !redirect_en;
        push_entry = '{inst: imem_rdata, pc: resp_pc_q};

        outst_d    = outst_q + CNT_W'(grant) - CNT_W'(rvalid_ok);

        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect_en) begin
            // Everything still outstanding after this cycle belongs to the old path.
            discard_d  = outst_q - CNT_W'(rvalid_ok);
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
        end else begin
            if (dropping) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_VECTOR;
            resp_pc_q  <= RESET_VECTOR;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_en),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Output payload; idle value is a NOP at pc 0.
    always_comb begin
        imem_addr = fetch_pc_q;
        out_valid = !fifo_empty;
        out_inst  = out_valid ? fifo_head.inst : NOP;
        out_pc    = out_valid ? fifo_head.pc : 32'h0;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: one DEPTH=2 and one DEPTH=3 instance share stimulus.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_gnt;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        mem_hold;

    logic        req2, rvalid2, ov2;
    logic [31:0] addr2, rdata2, oi2, op2;
    logic        req3, rvalid3, ov3;
    logic [31:0] addr3, rdata3, oi3, op3;

    logic [31:0] pend2[$];
    logic [31:0] pend3[$];

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch #(.RESET_VECTOR(32'h0), .DEPTH(2)) u_d2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (rvalid2),
        .imem_rdata  (rdata2),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .out_valid   (ov2),
        .out_ready   (out_ready),
        .out_inst    (oi2),
        .out_pc      (op2)
    );

    inst_fetch #(.RESET_VECTOR(32'h0), .DEPTH(3)) u_d3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req3),
        .imem_addr   (addr3),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (rvalid3),
        .imem_rdata  (rdata3),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .out_valid   (ov3),
        .out_ready   (out_ready),
        .out_inst    (oi3),
        .out_pc      (op3)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: in-order, one response per cycle, one cycle after grant unless held.
    // Not reset, so stale responses can outlive a DUT reset.
    always @(posedge clk) begin
        if (req2 && imem_gnt) pend2.push_back(addr2);
        if (req3 && imem_gnt) pend3.push_back(addr3);
        if (!mem_hold && pend2.size() != 0) begin
            rvalid2 <= 1'b1;
            rdata2  <= mem_data(pend2[0]);
            pend2.delete(0);
        end else begin
            rvalid2 <= 1'b0;
            rdata2  <= 32'h0;
        end
        if (!mem_hold && pend3.size() != 0) begin
            rvalid3 <= 1'b1;
            rdata3  <= mem_data(pend3[0]);
            pend3.delete(0);
        end else begin
            rvalid3 <= 1'b0;
            rdata3  <= 32'h0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        mem_hold    = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // sel 0: d2 out_valid; 1: d3 out_valid; 2: d3 out_valid with a response arriving.
    task automatic wait_cond(input int sel, input int budget, input string tag);
        logic hit;
        for (int i = 0; i < budget; i++) begin
            hit = (sel == 0) ? ov2 : (sel == 1) ? ov3 : (ov3 && rvalid3);
            if (hit) return;
            @(negedge clk);
        end
        hit = (sel == 0) ? ov2 : (sel == 1) ? ov3 : (ov3 && rvalid3);
        check_eq(tag, 32'(hit), 32'h1);
    endtask

    initial begin
        int          n2;
        int          grants;

        // Reset state
        do_reset();
        check_eq("rst_req", 32'(req2), 32'h0);
        check_eq("rst_addr", addr2, 32'h0);
        check_eq("rst_valid", 32'(ov2), 32'h0);
        check_eq("rst_inst", oi2, NOP);
        check_eq("rst_pc", op2, 32'h0);

        // Streaming from reset; d3 must deliver one instruction per cycle
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        check_eq("rel_req", 32'(req2), 32'h1);
        check_eq("rel_addr", addr2, 32'h0);
        n2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ov2) begin
                check_eq("stream_pc", op2, 32'(4 * n2));
                check_eq("stream_inst", oi2, mem_data(32'(4 * n2)));
                n2++;
            end
            if (k >= 2 && k <= 9) begin
                check_eq("tput_valid", 32'(ov3), 32'h1);
                check_eq("tput_pc", op3, 32'(4 * (k - 2)));
            end
        end
        check_eq("stream_cnt", 32'(n2 >= 6), 32'h1);

        // Back-pressure: DEPTH=2 allows exactly two grants, payload held
        do_reset();
        imem_gnt  = 1'b1;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        grants    = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req2 && imem_gnt) grants++;
            if (k >= 3) check_eq("hold_pc", op2, 32'h0);
            @(negedge clk);
        end
        check_eq("bp_grants", 32'(grants), 32'h2);
        check_eq("bp_req", 32'(req2), 32'h0);
        check_eq("bp_valid", 32'(ov2), 32'h1);
        check_eq("bp_pc", op2, 32'h0);
        check_eq("bp_inst", oi2, mem_data(32'h0));
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_next_pc", op2, 32'h4);

        // Redirect with two outstanding requests
        do_reset();
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        mem_hold  = 1'b1;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("two_out_req", 32'(req2), 32'h0);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0103;
        mem_hold    = 1'b0;
        @(negedge clk);
        redirect_en = 1'b0;
        #1;
        check_eq("redir_addr", addr2, 32'h0000_0100);
        check_eq("redir_valid", 32'(ov2), 32'h0);
        check_eq("redir_nop", oi2, NOP);
        wait_cond(0, 12, "redir_wait");
        check_eq("redir_pc", op2, 32'h0000_0100);
        check_eq("redir_inst", oi2, mem_data(32'h0000_0100));

        // Redirect colliding with response and pop; one response left to discard (d3)
        do_reset();
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        mem_hold  = 1'b1;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        mem_hold = 1'b0;
        wait_cond(2, 10, "coll_wait");
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check_eq("coll_req", 32'(req3), 32'h0);
        @(negedge clk);
        redirect_en = 1'b0;
        check_eq("coll_valid", 32'(ov3), 32'h0);
        wait_cond(1, 12, "coll_wait2");
        check_eq("coll_pc", op3, 32'h0000_0200);
        check_eq("coll_inst", oi3, mem_data(32'h0000_0200));

        // Address wrap at the top of memory; low bits of the target ignored
        do_reset();
        out_ready   = 1'b1;
        rst_n       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_en = 1'b0;
        imem_gnt    = 1'b1;
        #1;
        check_eq("wrap_addr0", addr2, 32'hFFFF_FFFC);
        check_eq("wrap_req", 32'(req2), 32'h1);
        @(negedge clk);
        check_eq("wrap_addr1", addr2, 32'h0);
        wait_cond(0, 10, "wrap_wait0");
        check_eq("wrap_pc0", op2, 32'hFFFF_FFFC);
        check_eq("wrap_inst0", oi2, mem_data(32'hFFFF_FFFC));
        @(negedge clk);
        wait_cond(0, 10, "wrap_wait1");
        check_eq("wrap_pc1", op2, 32'h0);

        // Reset with two requests in flight; stale responses must be ignored
        do_reset();
        imem_gnt  = 1'b1;
        out_ready = 1'b1;
        mem_hold  = 1'b1;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        rst_n    = 1'b0;
        imem_gnt = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(req2), 32'h0);
        check_eq("mid_rst_valid", 32'(ov2), 32'h0);
        check_eq("mid_rst_inst", oi2, NOP);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        #1;
        check_eq("post_rst_req", 32'(req2), 32'h1);
        check_eq("post_rst_addr", addr2, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stale_valid", 32'(ov2), 32'h0);
        end
        imem_gnt = 1'b1;
        wait_cond(0, 10, "post_rst_wait");
        check_eq("post_rst_pc", op2, 32'h0);
        check_eq("post_rst_inst", oi2, mem_data(32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
